dma_desc_engine: RTL and testbench
==================================

Name: dma_desc_engine

Overview:
- DMA engine sitting directly downstream of the transaction-layer stage: consumes its 128-bit DMA-bound stream (doorbell, then descriptor completion) and produces its 32-bit TL-bound stream (descriptor read request, then memory-write data TLPs).
- Per job: accept doorbell → issue one MRd for the descriptor → accept descriptor → stream payload from local buffer as one or more MWr TLPs → pulse done.

Parameters:
- ADDR_W, 8, local buffer word-address width
- MAX_PAYLOAD_DW, 4, max DWs per MWr TLP (power of 2, 1..64)
- REQ_ID, 16'h0100, requester ID placed in header DW1

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_tvalid  in  1  inbound beat valid (from TL)
- s_tready  out  1  inbound ready
- s_tlast  in  1  inbound last (must be 1; every inbound message is one beat)
- s_tuser  in  96  inbound header DWs (ignored by this block)
- s_tdata  in  128  inbound payload
- m_tvalid  out  1  outbound beat valid (to TL)
- m_tready  in  1  outbound ready
- m_tlast  out  1  last beat of outbound TLP
- m_tuser  out  96  outbound header {dw2,dw1,dw0}, dw0 in [31:0]
- m_tdata  out  32  outbound data DW
- mem_rd_en  out  1  local buffer read strobe
- mem_rd_addr  out  ADDR_W  local buffer word address
- mem_rd_data  in  32  read data, valid exactly 1 cycle after mem_rd_en
- busy  out  1  high in any state other than IDLE
- done  out  1  1-cycle pulse at job completion
- err  out  1  1-cycle pulse on rejected beat/descriptor

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset: state=IDLE; m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, mem_rd_en=0, mem_rd_addr=0, busy=0, done=0, err=0; tag=8'h00; skid FIFO emptied. Reset mid-job abandons the job; no further beats are emitted.
- Handshake: transfer on valid&&ready. m_tvalid, m_tdata, m_tuser and m_tlast hold stable while m_tvalid && !m_tready. s_tready is combinational: 1 in IDLE and WAIT_DESC, else 0.
- IDLE: on s beat, doorbell addr DA=s_tdata[31:0] is latched → RDREQ.
- RDREQ: registered m_tvalid=1, m_tlast=1, m_tuser = {32'h0, {REQ_ID,tag,8'hFF}, 32'h0000_0004}, m_tdata=DA. On accept → WAIT_DESC.
- WAIT_DESC: on s beat, latch SRC=s_tdata[ADDR_W-1:0], DST=s_tdata[63:32], LEN=s_tdata[95:64]. If LEN==0 or LEN>2**ADDR_W: err pulse, tag+1, → IDLE. Else → WR_DATA.
- Any inbound beat with s_tlast=0 is consumed, dropped, and pulses err; the state does not change.
- WR_DATA: payload is split into TLPs of n=min(remaining,MAX_PAYLOAD_DW) DWs. Every beat of a TLP carries m_tuser = {cur_dst, {REQ_ID,tag,8'hFF}, {8'h40,14'h0,n[9:0]}}. m_tlast=1 on the n-th beat. After each TLP, cur_dst+=4*n (32-bit wrap) and remaining-=n.
- Fetch: mem_rd_addr starts at SRC and increments per read, wrapping modulo 2**ADDR_W. mem_rd_en asserts while fetched<LEN and (fifo_occupancy+outstanding)<2. Read data enters a 2-entry FIFO that drives the m_* output register. Sustained throughput is 1 DW/cycle with m_tready held high. Words are emitted in order, with no duplication or loss under any m_tready pattern.
- When the final beat (remaining→0) is accepted: state → DONE.
- DONE: done=1 for one cycle, tag increments (8-bit wrap), → IDLE.
- Latency: first payload beat m_tvalid appears 2 cycles after descriptor acceptance.

Test Plan:
- Doorbell s_tdata[31:0]=32'h0000_1000 → one beat: m_tdata=32'h1000, m_tuser[31:0]=32'h4, m_tuser[63:32]=32'h0100_00FF, m_tlast=1; busy=1.
- Descriptor SRC=0, DST=32'h2000, LEN=6, buffer[i]=i+32'hA0 → TLP1: 4 beats A0..A3, dw0=32'h4000_0004, dw2=32'h2000. TLP2: beats A4,A5, dw0=32'h4000_0002, dw2=32'h2010. m_tlast on beats 4 and 6; done pulses once; busy drops.
- Same job with m_tready random at 50% → identical beat sequence and tuser values; stable outputs while stalled.
- Descriptor LEN=0, and a separate case with LEN=300 (ADDR_W=8) → err pulse, no MWr beats, back in IDLE; next doorbell's MRd carries tag=01.
- SRC=8'hFE, LEN=3 → reads addrs FE, FF, 00; a doorbell beat with s_tlast=0 in IDLE → err pulse, state remains IDLE.
- rst asserted mid-WR_DATA after 2 beats → next cycle m_tvalid=0, busy=0, tag=0; a fresh job then completes normally.

Source files
------------

// File: rtl/dma_desc_engine.sv
// Descriptor-driven DMA engine: doorbell -> descriptor MRd -> descriptor -> MWr TLP stream -> done.
// Payload words are fetched from a local buffer through a 2-entry skid FIFO feeding a registered output.
module dma_desc_engine #(
  parameter int          ADDR_W         = 8,
  parameter int          MAX_PAYLOAD_DW = 4,
  parameter logic [15:0] REQ_ID         = 16'h0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic [95:0]       s_tuser,
  input  logic [127:0]      s_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [95:0]       m_tuser,
  output logic [31:0]       m_tdata,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_RDREQ, S_WAIT_DESC, S_WR_DATA, S_DONE} state_t;

  localparam int          NW        = 7;
  localparam logic [31:0] MAX_DW    = 32'(MAX_PAYLOAD_DW);
  localparam logic [32:0] BUF_WORDS = 33'(1) << ADDR_W;

  state_t            r_state;
  logic [7:0]        r_tag;
  logic              r_m_tvalid, r_m_tlast;
  logic [95:0]       r_m_tuser;
  logic [31:0]       r_m_tdata;
  logic              r_mem_rd_en, r_rd_vld;
  logic [ADDR_W-1:0] r_mem_rd_addr, r_rd_ptr;
  logic              r_done, r_err, r_final;
  logic [31:0]       r_len, r_fetched, r_ld_rem, r_cur_dst;
  logic [NW-1:0]     r_tlp_left, r_tlp_n;
  logic [31:0]       r_fifo [0:1];
  logic              r_fifo_wr, r_fifo_rd;
  logic [1:0]        r_fifo_cnt;

  logic              w_out_free, w_have_src, w_load, w_pop, w_push, w_issue, w_first;
  logic              w_desc_ok;
  logic [31:0]       w_word, w_len;
  logic [NW-1:0]     w_min, w_n, w_left;
  logic [2:0]        w_cnt_next;
  logic              w_unused_ok;

  assign w_unused_ok = ^{s_tuser, s_tdata[127:96]};

  always_comb begin
    w_out_free = !r_m_tvalid || m_tready;
    w_have_src = (r_fifo_cnt != 2'd0) || r_rd_vld;
    w_load     = (r_state == S_WR_DATA) && w_out_free && w_have_src;
    w_pop      = w_load && (r_fifo_cnt != 2'd0);
    // Read data bypasses the FIFO when it is empty and the output register is free.
    w_push     = r_rd_vld && !(w_load && (r_fifo_cnt == 2'd0));
    w_word     = (r_fifo_cnt != 2'd0) ? r_fifo[r_fifo_rd] : mem_rd_data;
    w_cnt_next = {1'b0, r_fifo_cnt} + {2'b00, w_push} - {2'b00, w_pop};
    // Reads still in flight after this edge plus FIFO contents may never exceed two.
    w_issue    = (r_state == S_WR_DATA) && (r_fetched < r_len) &&
                 ((w_cnt_next + {2'b00, r_mem_rd_en}) < 3'd2);
    w_min      = (r_ld_rem < MAX_DW) ? r_ld_rem[NW-1:0] : MAX_DW[NW-1:0];
    w_first    = (r_tlp_left == '0);
    w_n        = w_first ? w_min : r_tlp_n;
    w_left     = w_first ? w_min : r_tlp_left;
    w_len      = s_tdata[95:64];
    w_desc_ok  = (w_len != 32'd0) && ({1'b0, w_len} <= BUF_WORDS);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_fifo_wr] <= mem_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_tag         <= 8'h00;
      r_m_tvalid    <= 1'b0;
      r_m_tlast     <= 1'b0;
      r_m_tuser     <= '0;
      r_m_tdata     <= '0;
      r_mem_rd_en   <= 1'b0;
      r_rd_vld      <= 1'b0;
      r_mem_rd_addr <= '0;
      r_rd_ptr      <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_final       <= 1'b0;
      r_len         <= '0;
      r_fetched     <= '0;
      r_ld_rem      <= '0;
      r_cur_dst     <= '0;
      r_tlp_left    <= '0;
      r_tlp_n       <= '0;
      r_fifo_wr     <= 1'b0;
      r_fifo_rd     <= 1'b0;
      r_fifo_cnt    <= '0;
    end else begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_rd_en <= w_issue;
      r_rd_vld    <= r_mem_rd_en;
      r_fifo_cnt  <= w_cnt_next[1:0];
      if (w_push) r_fifo_wr <= ~r_fifo_wr;
      if (w_pop)  r_fifo_rd <= ~r_fifo_rd;
      if (w_issue) begin
        r_mem_rd_addr <= r_rd_ptr;
        r_rd_ptr      <= r_rd_ptr + ADDR_W'(1);
        r_fetched     <= r_fetched + 32'd1;
      end
      case (r_state)
        S_IDLE: if (s_tvalid) begin
          if (!s_tlast) begin
            r_err <= 1'b1;
          end else begin
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= 1'b1;
            r_m_tuser  <= {32'h0, REQ_ID, r_tag, 8'hFF, 32'h0000_0004};
            r_m_tdata  <= s_tdata[31:0];
            r_state    <= S_RDREQ;
          end
        end
        S_RDREQ: if (m_tready) begin
          r_m_tvalid <= 1'b0;
          r_state    <= S_WAIT_DESC;
        end
        S_WAIT_DESC: if (s_tvalid) begin
          if (!s_tlast) begin
            r_err <= 1'b1;
          end else if (!w_desc_ok) begin
            r_err   <= 1'b1;
            r_tag   <= r_tag + 8'd1;
            r_state <= S_IDLE;
          end else begin
            // First fetch is issued on the acceptance edge to keep first-beat latency at two cycles.
            r_state       <= S_WR_DATA;
            r_len         <= w_len;
            r_ld_rem      <= w_len;
            r_cur_dst     <= s_tdata[63:32];
            r_mem_rd_en   <= 1'b1;
            r_mem_rd_addr <= s_tdata[ADDR_W-1:0];
            r_rd_ptr      <= s_tdata[ADDR_W-1:0] + ADDR_W'(1);
            r_fetched     <= 32'd1;
            r_tlp_left    <= '0;
            r_final       <= 1'b0;
          end
        end
        S_WR_DATA: begin
          if (w_load) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_word;
            r_m_tlast  <= (w_left == NW'(1));
            r_m_tuser  <= {r_cur_dst, REQ_ID, r_tag, 8'hFF, 8'h40, 14'h0, 10'(w_n)};
            r_tlp_left <= w_left - NW'(1);
            r_tlp_n    <= w_n;
            r_ld_rem   <= r_ld_rem - 32'd1;
            r_final    <= (r_ld_rem == 32'd1);
            if (w_left == NW'(1)) r_cur_dst <= r_cur_dst + {23'h0, w_n, 2'b00};
          end else if (r_m_tvalid && m_tready) begin
            r_m_tvalid <= 1'b0;
          end
          if (r_m_tvalid && m_tready && r_final) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_tag   <= r_tag + 8'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_tready    = (r_state == S_IDLE) || (r_state == S_WAIT_DESC);
  assign m_tvalid    = r_m_tvalid;
  assign m_tlast     = r_m_tlast;
  assign m_tuser     = r_m_tuser;
  assign m_tdata     = r_m_tdata;
  assign mem_rd_en   = r_mem_rd_en;
  assign mem_rd_addr = r_mem_rd_addr;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_dma_desc_engine.sv
// Directed bench for dma_desc_engine: MRd generation, TLP splitting, stalls, descriptor
// rejection, buffer address wrap, malformed beats and mid-job reset.
module tb_dma_desc_engine;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_tvalid, s_tready, s_tlast;
  logic [95:0]       s_tuser;
  logic [127:0]      s_tdata;
  logic              m_tvalid, m_tready, m_tlast;
  logic [95:0]       m_tuser;
  logic [31:0]       m_tdata;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data = '0;
  logic              busy, done, err;

  int n_checks = 0;
  int n_fails  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [31:0]       mem [256];
  logic [31:0]       q_data [$];
  logic [95:0]       q_user [$];
  logic              q_last [$];
  logic [ADDR_W-1:0] q_addr [$];

  // Expected beats for SRC=0, DST=0x2000, LEN=6 with buffer[i]=i+0xA0
  logic [31:0] E6_DATA [6] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
  logic [31:0] E6_DW0  [6] = '{32'h4000_0004, 32'h4000_0004, 32'h4000_0004, 32'h4000_0004,
                               32'h4000_0002, 32'h4000_0002};
  logic [31:0] E6_DW2  [6] = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h2010, 32'h2010};
  logic        E6_LAST [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  dma_desc_engine #(.ADDR_W(ADDR_W), .MAX_PAYLOAD_DW(4), .REQ_ID(16'h0100)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tuser(s_tuser), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tdata(m_tdata),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) begin
        q_data.push_back(m_tdata);
        q_user.push_back(m_tuser);
        q_last.push_back(m_tlast);
        $display("beat data=%h user=%h last=%b", m_tdata, m_tuser, m_tlast);
      end
      if (mem_rd_en) q_addr.push_back(mem_rd_addr);
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    q_data.delete(); q_user.delete(); q_last.delete(); q_addr.delete();
    done_cnt = 0; err_cnt = 0;
  endtask

  task automatic drive_beat(input logic [127:0] d, input logic last);
    @(posedge clk); #1;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b1;
  endtask

  // Doorbell plus MRd acceptance; requires m_tready=1.
  task automatic start_job(input logic [31:0] da);
    drive_beat({96'h0, da}, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({m_tvalid, m_tlast} !== 2'b00) begin n_fails++; $display("FAIL reset_valid_last: got %b required 00", {m_tvalid, m_tlast}); end
    n_checks++; if (m_tuser !== 96'h0) begin n_fails++; $display("FAIL reset_tuser: got %h required 0", m_tuser); end
    n_checks++; if (m_tdata !== 32'h0) begin n_fails++; $display("FAIL reset_tdata: got %h required 0", m_tdata); end
    n_checks++; if ({mem_rd_en, mem_rd_addr} !== 9'h0) begin n_fails++; $display("FAIL reset_mem: got en=%b addr=%h required 0", mem_rd_en, mem_rd_addr); end
    n_checks++; if ({busy, done, err} !== 3'b000) begin n_fails++; $display("FAIL reset_status: got %b required 000", {busy, done, err}); end
    n_checks++; if (s_tready !== 1'b1) begin n_fails++; $display("FAIL reset_s_tready: got %b required 1", s_tready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_doorbell();
    clear_q();
    m_tready = 1'b0;
    drive_beat({96'h0, 32'h0000_1000}, 1'b1);
    @(negedge clk);
    n_checks++; if ({m_tvalid, m_tlast} !== 2'b11) begin n_fails++; $display("FAIL mrd_valid_last: got %b required 11", {m_tvalid, m_tlast}); end
    n_checks++; if (m_tdata !== 32'h0000_1000) begin n_fails++; $display("FAIL mrd_tdata: got %h required 00001000", m_tdata); end
    n_checks++; if (m_tuser !== {32'h0, 32'h0100_00FF, 32'h0000_0004}) begin n_fails++; $display("FAIL mrd_tuser: got %h required 00000000010000ff00000004", m_tuser); end
    n_checks++; if ({busy, s_tready} !== 2'b10) begin n_fails++; $display("FAIL mrd_busy_ready: got %b required 10", {busy, s_tready}); end
    repeat (3) @(negedge clk);
    n_checks++; if ({m_tvalid, m_tdata} !== {1'b1, 32'h0000_1000}) begin n_fails++; $display("FAIL mrd_stall_hold: got v=%b d=%h required v=1 d=00001000", m_tvalid, m_tdata); end
    @(posedge clk); #1;
    m_tready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if ({m_tvalid, s_tready} !== 2'b01) begin n_fails++; $display("FAIL mrd_accepted: got v=%b rdy=%b required v=0 rdy=1", m_tvalid, s_tready); end
    n_checks++; if (q_data.size() != 1) begin n_fails++; $display("FAIL mrd_count: got %0d beats required 1", q_data.size()); end
  endtask

  task automatic test_single_job();
    @(posedge clk); #1;
    clear_q();
    drive_beat({32'h0, 32'd6, 32'h0000_2000, 32'h0}, 1'b1);
    @(negedge clk);
    n_checks++; if ({m_tvalid, mem_rd_en, mem_rd_addr} !== {1'b0, 1'b1, 8'h00}) begin n_fails++; $display("FAIL job_first_read: got v=%b en=%b addr=%h required v=0 en=1 addr=00", m_tvalid, mem_rd_en, mem_rd_addr); end
    @(negedge clk);
    n_checks++; if (m_tvalid !== 1'b0) begin n_fails++; $display("FAIL job_latency_early: got m_tvalid=%b required 0", m_tvalid); end
    @(negedge clk);
    n_checks++; if ({m_tvalid, m_tdata} !== {1'b1, 32'hA0}) begin n_fails++; $display("FAIL job_latency: got v=%b d=%h required v=1 d=000000a0", m_tvalid, m_tdata); end
    wait_done();
    n_checks++; if (done_cnt != 1) begin n_fails++; $display("FAIL job_done: got %0d pulses required 1", done_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL job_busy: got %b required 0", busy); end
    n_checks++; if (q_data.size() != 6) begin n_fails++; $display("FAIL job_count: got %0d beats required 6", q_data.size()); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (q_data.size() <= i || q_data[i] !== E6_DATA[i] || q_last[i] !== E6_LAST[i] ||
          q_user[i] !== {E6_DW2[i], 32'h0100_00FF, E6_DW0[i]}) begin
        n_fails++;
        $display("FAIL job_beat%0d: got d=%h u=%h l=%b required d=%h u=%h%h%h l=%b", i,
                 q_data[i], q_user[i], q_last[i], E6_DATA[i], E6_DW2[i], 32'h0100_00FF, E6_DW0[i], E6_LAST[i]);
      end
    end
  endtask

  task automatic test_random_ready();
    logic [128:0] saved;
    logic         stalled;
    clear_q();
    m_tready = 1'b1;
    start_job(32'h0000_1000);
    n_checks++; if (q_user.size() != 1 || q_user[0][63:32] !== 32'h0100_01FF) begin n_fails++; $display("FAIL rnd_mrd_tag: got %h required 010001ff", q_user[0][63:32]); end
    clear_q();
    m_tready = 1'b0;
    drive_beat({32'h0, 32'd6, 32'h0000_2000, 32'h0}, 1'b1);
    stalled = 1'b0;
    saved   = '0;
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (stalled) begin
        n_checks++;
        if (!m_tvalid || {m_tlast, m_tuser, m_tdata} !== saved) begin
          n_fails++;
          $display("FAIL rnd_stall_hold: got v=%b %h required v=1 %h", m_tvalid, {m_tlast, m_tuser, m_tdata}, saved);
        end
      end
      m_tready = 1'($urandom_range(0, 1));
      stalled  = m_tvalid && !m_tready;
      saved    = {m_tlast, m_tuser, m_tdata};
    end
    m_tready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (done_cnt != 1) begin n_fails++; $display("FAIL rnd_done: got %0d pulses required 1", done_cnt); end
    n_checks++; if (q_data.size() != 6) begin n_fails++; $display("FAIL rnd_count: got %0d beats required 6", q_data.size()); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (q_data.size() <= i || q_data[i] !== E6_DATA[i] || q_last[i] !== E6_LAST[i] ||
          q_user[i] !== {E6_DW2[i], 32'h0100_01FF, E6_DW0[i]}) begin
        n_fails++;
        $display("FAIL rnd_beat%0d: got d=%h u=%h l=%b required d=%h u=%h%h%h l=%b", i,
                 q_data[i], q_user[i], q_last[i], E6_DATA[i], E6_DW2[i], 32'h0100_01FF, E6_DW0[i], E6_LAST[i]);
      end
    end
  endtask

  task automatic test_bad_len();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    clear_q();
    m_tready = 1'b1;
    start_job(32'h0000_1000);
    clear_q();
    drive_beat({32'h0, 32'd0, 32'h0000_2000, 32'h0}, 1'b1);
    @(negedge clk);
    n_checks++; if ({err, busy} !== 2'b10) begin n_fails++; $display("FAIL len0_err: got err=%b busy=%b required err=1 busy=0", err, busy); end
    repeat (5) begin @(posedge clk); #1; end
    n_checks++; if (q_data.size() != 0 || err_cnt != 1) begin n_fails++; $display("FAIL len0_quiet: got %0d beats %0d errs required 0 beats 1 err", q_data.size(), err_cnt); end
    clear_q();
    start_job(32'h0000_1000);
    n_checks++; if (q_user.size() != 1 || q_user[0][63:32] !== 32'h0100_01FF) begin n_fails++; $display("FAIL len0_next_tag: got %h required 010001ff", q_user[0][63:32]); end
    clear_q();
    drive_beat({32'h0, 32'd300, 32'h0000_2000, 32'h0}, 1'b1);
    @(negedge clk);
    n_checks++; if ({err, busy, s_tready} !== 3'b101) begin n_fails++; $display("FAIL len300_err: got err/busy/rdy=%b required 101", {err, busy, s_tready}); end
    repeat (5) begin @(posedge clk); #1; end
    n_checks++; if (q_data.size() != 0 || q_addr.size() != 0) begin n_fails++; $display("FAIL len300_quiet: got %0d beats %0d reads required 0", q_data.size(), q_addr.size()); end
  endtask

  task automatic test_addr_wrap();
    clear_q();
    start_job(32'h0000_1000);
    n_checks++; if (q_user.size() != 1 || q_user[0][63:32] !== 32'h0100_02FF) begin n_fails++; $display("FAIL wrap_mrd_tag: got %h required 010002ff", q_user[0][63:32]); end
    clear_q();
    drive_beat({32'h0, 32'd3, 32'h0000_3000, 32'h0000_00FE}, 1'b1);
    wait_done();
    n_checks++;
    if (q_addr.size() != 3 || q_addr[0] !== 8'hFE || q_addr[1] !== 8'hFF || q_addr[2] !== 8'h00) begin
      n_fails++;
      $display("FAIL wrap_addrs: got n=%0d %h %h %h required n=3 fe ff 00", q_addr.size(), q_addr[0], q_addr[1], q_addr[2]);
    end
    n_checks++;
    if (q_data.size() != 3 || q_data[0] !== 32'h19E || q_data[1] !== 32'h19F || q_data[2] !== 32'hA0) begin
      n_fails++;
      $display("FAIL wrap_data: got n=%0d %h %h %h required n=3 19e 19f a0", q_data.size(), q_data[0], q_data[1], q_data[2]);
    end
    n_checks++;
    if (q_user.size() != 3 || q_user[2] !== {32'h0000_3000, 32'h0100_02FF, 32'h4000_0003} ||
        {q_last[0], q_last[1], q_last[2]} !== 3'b001) begin
      n_fails++;
      $display("FAIL wrap_hdr: got u=%h last=%b%b%b required u=00003000010002ff40000003 last=001",
               q_user[2], q_last[0], q_last[1], q_last[2]);
    end
    n_checks++; if (done_cnt != 1) begin n_fails++; $display("FAIL wrap_done: got %0d pulses required 1", done_cnt); end
  endtask

  task automatic test_tlast0();
    clear_q();
    drive_beat({96'h0, 32'h0000_5000}, 1'b0);
    @(negedge clk);
    n_checks++; if ({err, busy, m_tvalid} !== 3'b100) begin n_fails++; $display("FAIL tlast0_err: got err/busy/valid=%b required 100", {err, busy, m_tvalid}); end
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (err_cnt != 1 || busy !== 1'b0 || q_data.size() != 0) begin n_fails++; $display("FAIL tlast0_idle: got errs=%0d busy=%b beats=%0d required 1 0 0", err_cnt, busy, q_data.size()); end
  endtask

  task automatic test_reset_mid();
    clear_q();
    start_job(32'h0000_1000);
    clear_q();
    drive_beat({32'h0, 32'd6, 32'h0000_2000, 32'h0}, 1'b1);
    for (int i = 0; i < 50 && q_data.size() < 2; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if ({m_tvalid, busy, mem_rd_en} !== 3'b000) begin n_fails++; $display("FAIL rstmid_quiet: got valid/busy/rd=%b required 000", {m_tvalid, busy, mem_rd_en}); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    n_checks++; if (q_data.size() != 2) begin n_fails++; $display("FAIL rstmid_count: got %0d beats required 2", q_data.size()); end
    clear_q();
    start_job(32'h0000_1000);
    n_checks++; if (q_user.size() != 1 || q_user[0][63:32] !== 32'h0100_00FF) begin n_fails++; $display("FAIL rstmid_tag: got %h required 010000ff", q_user[0][63:32]); end
    clear_q();
    drive_beat({32'h0, 32'd6, 32'h0000_2000, 32'h0}, 1'b1);
    wait_done();
    n_checks++; if (done_cnt != 1 || q_data.size() != 6) begin n_fails++; $display("FAIL rstmid_job: got done=%0d beats=%0d required 1 6", done_cnt, q_data.size()); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (q_data.size() <= i || q_data[i] !== E6_DATA[i] || q_last[i] !== E6_LAST[i] ||
          q_user[i] !== {E6_DW2[i], 32'h0100_00FF, E6_DW0[i]}) begin
        n_fails++;
        $display("FAIL rstmid_beat%0d: got d=%h u=%h l=%b required d=%h u=%h%h%h l=%b", i,
                 q_data[i], q_user[i], q_last[i], E6_DATA[i], E6_DW2[i], 32'h0100_00FF, E6_DW0[i], E6_LAST[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) + 32'hA0;
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b1; s_tuser = '0; s_tdata = '0; m_tready = 1'b0;
    test_reset();
    test_doorbell();
    test_single_job();
    test_random_ready();
    test_bad_len();
    test_addr_wrap();
    test_tlast0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
